// File: rtl/uart_cmd_parser.sv
// Assembles 5-byte command frames (header, cmd, data hi, data lo, checksum) from the UART byte stream.
// It validates checksum and command range, and drops partial frames after an inter-byte timeout.
module uart_cmd_parser #(
    parameter logic [7:0] HEADER      = 8'h55,
    parameter int          CMD_NUM     = 8,
    parameter int          TIMEOUT_CYC = 200000,
    parameter int          CNT_W       = 18
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  din,
    input  logic        din_vld,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_vld,
    output logic        err,
    output logic [1:0]  err_code
);

    // state | meaning
    // IDLE  | hunting for HEADER, other bytes dropped
    // CMD   | expecting command byte
    // DHI   | expecting data high byte
    // DLO   | expecting data low byte
    // CHK   | expecting checksum byte
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CMD  = 3'd1;
    localparam logic [2:0] S_DHI  = 3'd2;
    localparam logic [2:0] S_DLO  = 3'd3;
    localparam logic [2:0] S_CHK  = 3'd4;

    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [8:0]       CMD_LIM    = 9'(CMD_NUM);

    logic [2:0]       state;
    logic [7:0]       cmd_byte;
    logic [7:0]       data_hi;
    logic [7:0]       data_lo;
    logic [7:0]       csum;
    logic [CNT_W-1:0] timer;
    logic             timeout;
    logic             cmd_ok;

    // An arriving byte always beats the timeout on the same cycle.
    assign timeout = (state != S_IDLE) && !din_vld && (timer == TIMER_LAST);
    assign cmd_ok  = ({1'b0, cmd_byte} < CMD_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cmd_byte <= '0;
            data_hi  <= '0;
            data_lo  <= '0;
            csum     <= '0;
            timer    <= '0;
            cmd      <= '0;
            data     <= '0;
            cmd_vld  <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
        end else begin
            cmd_vld <= 1'b0;
            err     <= 1'b0;

            if (din_vld || state == S_IDLE || timeout)
                timer <= '0;
            else
                timer <= timer + 1'b1;

            if (timeout) begin
                state    <= S_IDLE;
                err      <= 1'b1;
                err_code <= 2'b10;
            end else if (din_vld) begin
                case (state)
                    S_IDLE: begin
                        if (din == HEADER) begin
                            state <= S_CMD;
                            csum  <= '0;
                        end
                    end
                    S_CMD: begin
                        cmd_byte <= din;
                        csum     <= din;
                        state    <= S_DHI;
                    end
                    S_DHI: begin
                        data_hi <= din;
                        csum    <= csum + din;
                        state   <= S_DLO;
                    end
                    S_DLO: begin
                        data_lo <= din;
                        csum    <= csum + din;
                        state   <= S_CHK;
                    end
                    S_CHK: begin
                        state <= S_IDLE;
                        if (din != csum) begin
                            err      <= 1'b1;
                            err_code <= 2'b01;
                        end else if (!cmd_ok) begin
                            err      <= 1'b1;
                            err_code <= 2'b11;
                        end else begin
                            cmd     <= cmd_byte;
                            data    <= {data_hi, data_lo};
                            cmd_vld <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: a table of whole frames plus hand-written
// sequences for garbage, timeout, timeout boundary and mid-frame reset.
module tb_uart_cmd_parser;

    localparam int T = 20;

    logic        clk;
    logic        rst_n;
    logic [7:0]  din;
    logic        din_vld;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_vld;
    logic        err;
    logic [1:0]  err_code;

    int checks   = 0;
    int failures = 0;

    uart_cmd_parser #(
        .HEADER      (8'h55),
        .CMD_NUM     (8),
        .TIMEOUT_CYC (T),
        .CNT_W       (5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .din_vld  (din_vld),
        .cmd      (cmd),
        .data     (data),
        .cmd_vld  (cmd_vld),
        .err      (err),
        .err_code (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [39:0] bytes;
        logic        exp_vld;
        logic        exp_err;
        logic [1:0]  exp_code;
        logic [7:0]  exp_cmd;
        logic [15:0] exp_data;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge with the byte consumed.
    task automatic send_byte(input logic [7:0] b);
        din     = b;
        din_vld = 1'b1;
        @(negedge clk);
        din_vld = 1'b0;
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_vld"}, 32'(cmd_vld), 32'd0);
        chk({name, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic chk_result(input string name, input logic v, input logic e,
                              input logic [1:0] code, input logic [7:0] c, input logic [15:0] d);
        chk({name, "_cmd_vld"}, 32'(cmd_vld), 32'(v));
        chk({name, "_err"}, 32'(err), 32'(e));
        chk({name, "_err_code"}, 32'(err_code), 32'(code));
        chk({name, "_cmd"}, 32'(cmd), 32'(c));
        chk({name, "_data"}, 32'(data), 32'(d));
    endtask

    always @(negedge clk) begin
        if (cmd_vld && err) begin
            failures++;
            $display("FAIL exclusive cmd_vld=%0b err=%0b required not both", cmd_vld, err);
        end
    end

    vec_t vecs [8];

    initial begin
        vecs[0] = '{40'h55_03_01_F4_F8, 1'b1, 1'b0, 2'b00, 8'h03, 16'h01F4};
        vecs[1] = '{40'h55_03_01_F4_F9, 1'b0, 1'b1, 2'b01, 8'h03, 16'h01F4};
        vecs[2] = '{40'h55_09_00_10_19, 1'b0, 1'b1, 2'b11, 8'h03, 16'h01F4};
        vecs[3] = '{40'h55_07_12_34_4D, 1'b1, 1'b0, 2'b11, 8'h07, 16'h1234};
        vecs[4] = '{40'h55_08_00_00_08, 1'b0, 1'b1, 2'b11, 8'h07, 16'h1234};
        vecs[5] = '{40'h55_09_00_10_00, 1'b0, 1'b1, 2'b01, 8'h07, 16'h1234};
        vecs[6] = '{40'h55_00_FF_FF_FE, 1'b1, 1'b0, 2'b01, 8'h00, 16'hFFFF};
        vecs[7] = '{40'h55_05_55_55_AF, 1'b1, 1'b0, 2'b01, 8'h05, 16'h5555};

        rst_n   = 1'b0;
        din     = 8'h00;
        din_vld = 1'b0;
        repeat (2) @(negedge clk);
        chk_result("reset", 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        // Garbage ahead of a frame whose payload holds HEADER-valued bytes.
        send_byte(8'h00); chk_quiet("garbage00");
        send_byte(8'hAA); chk_quiet("garbageAA");
        send_byte(8'h55); send_byte(8'h01); send_byte(8'h55); send_byte(8'h00);
        chk_quiet("garbage_mid");
        send_byte(8'h56);
        chk_result("garbage_frame", 1'b1, 1'b0, 2'b00, 8'h01, 16'h5500);

        // Frames back-to-back: each header lands in the cycle the previous result is visible.
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++) begin
                send_byte(vecs[i].bytes[39 - 8*k -: 8]);
                chk_quiet($sformatf("vec%0d_b%0d", i, k));
            end
            send_byte(vecs[i].bytes[7:0]);
            chk_result($sformatf("vec%0d", i), vecs[i].exp_vld, vecs[i].exp_err,
                       vecs[i].exp_code, vecs[i].exp_cmd, vecs[i].exp_data);
        end
        @(negedge clk);
        chk_quiet("pulse_end");

        // Truncated frame: error appears exactly TIMEOUT_CYC+1 negedges after the last byte.
        send_byte(8'h55);
        send_byte(8'h02);
        repeat (T - 1) @(negedge clk);
        chk("timeout_early_err", 32'(err), 32'd0);
        @(negedge clk);
        chk("timeout_err", 32'(err), 32'd1);
        chk("timeout_code", 32'(err_code), 32'(2'b10));
        chk("timeout_no_vld", 32'(cmd_vld), 32'd0);
        @(negedge clk);
        chk("timeout_pulse", 32'(err), 32'd0);
        send_byte(8'h55); send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h02);
        chk_result("after_timeout", 1'b1, 1'b0, 2'b10, 8'h02, 16'h0000);

        // Byte arrives on the very cycle the timer reaches its last value.
        send_byte(8'h55);
        send_byte(8'h06);
        for (int k = 0; k < T - 1; k++) begin
            @(negedge clk);
            chk("boundary_wait_err", 32'(err), 32'd0);
        end
        send_byte(8'h00);
        chk_quiet("boundary_byte");
        send_byte(8'h0A);
        send_byte(8'h10);
        chk_result("boundary_frame", 1'b1, 1'b0, 2'b10, 8'h06, 16'h000A);

        // Reset in the middle of a frame.
        send_byte(8'h55);
        send_byte(8'h01);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_result("midreset", 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        chk_quiet("midreset_after");
        send_byte(8'h55); send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h02);
        chk_result("midreset_frame", 1'b1, 1'b0, 2'b00, 8'h02, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Consumes the byte stream of the UART receiver (byte + 1-cycle valid strobe) and assembles fixed 5-byte command frames: header, command, data high, data low, checksum.
- Validates header, command range and checksum; presents a decoded command/data word with a 1-cycle strobe to the temperature-monitor control logic.
- Runs an inter-byte timeout so a truncated frame cannot wedge the parser.

Parameters:
- HEADER, 8'h55, frame start byte.
- CMD_NUM, 8, number of legal command codes (0..CMD_NUM-1).
- TIMEOUT_CYC, 200000, max clk cycles allowed between bytes inside a frame.
- CNT_W, 18, width of timeout counter; must hold TIMEOUT_CYC-1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- din  input  8  received byte from UART receiver.
- din_vld  input  1  1-cycle strobe; din valid when high.
- cmd  output  8  decoded command code.
- data  output  16  decoded data word, {data_hi, data_lo}.
- cmd_vld  output  1  1-cycle strobe; cmd/data valid.
- err  output  1  1-cycle strobe on frame error.
- err_code  output  2  01 checksum, 10 timeout, 11 illegal command; holds until next err.

Behaviour:
- Reset (async, rst_n low): state IDLE, cmd=0, data=0, cmd_vld=0, err=0, err_code=0, internal byte regs, checksum and timer = 0.
- All outputs registered; no combinational path din/din_vld -> outputs.
- States: IDLE, CMD, DHI, DLO, CHK. Transitions occur only on din_vld, except timeout.
- IDLE: din_vld && din==HEADER -> CMD, clear checksum. Any other byte discarded silently, no err.
- CMD: on din_vld latch cmd byte, checksum=din -> DHI.
- DHI: on din_vld latch hi, checksum+=din (mod 256) -> DLO.
- DLO: on din_vld latch lo, checksum+=din (mod 256) -> CHK.
- CHK: on din_vld -> IDLE and, in the next cycle:
  - din==checksum && cmd_byte<CMD_NUM: cmd, data updated; cmd_vld=1 for one cycle.
  - din!=checksum: err=1, err_code=01; cmd/data unchanged.
  - checksum ok, cmd_byte>=CMD_NUM: err=1, err_code=11; cmd/data unchanged.
  - Checksum error takes priority over illegal command.
- Latency: cmd_vld/err asserts exactly 1 cycle after the din_vld of the checksum byte.
- A HEADER-valued byte inside a frame is payload, not resync.
- Timeout:
  - Timer clears on every din_vld and while in IDLE.
  - Otherwise it increments each cycle.
  - When timer==TIMEOUT_CYC-1 with no din_vld that cycle: next state IDLE, err=1, err_code=10 the following cycle, and the timer clears.
- Simultaneous din_vld and timer==TIMEOUT_CYC-1: the byte wins; it is processed normally, the timer clears and no timeout is raised.
- Back-to-back frames: a HEADER may arrive in any cycle after CHK completes, including the cycle cmd_vld is high; that header is accepted.
- cmd_vld and err are never high in the same cycle.
- Reset mid-frame: parser returns to IDLE, partial frame discarded, no err.

Test Plan:
- Frame 55 03 01 F4 F8 -> 1 cycle after last din_vld: cmd_vld=1, cmd=03, data=01F4, err=0.
- Frame 55 03 01 F4 F9 -> err=1, err_code=01, cmd_vld=0, cmd/data keep prior values.
- Frame 55 09 00 10 19, CMD_NUM=8 -> err=1, err_code=11, no cmd_vld.
- Bytes 55 02 then silence for TIMEOUT_CYC cycles -> err pulse with err_code=10, state IDLE. A following full frame 55 02 00 00 02 -> cmd_vld=1, cmd=02, data=0000.
- Timeout boundary: inject a byte exactly on the cycle the timer reaches TIMEOUT_CYC-1 -> no err, frame completes normally.
- Garbage 00 AA 55 01 55 00 56 -> leading 00 and AA ignored with no err. Payload 0x55 treated as data: cmd=01, data=5500, cmd_vld=1.
- Assert rst_n mid-frame after 55 01 -> no outputs. The next clean frame parses correctly.
